// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port RAM arbiter between icache and dcache.
// Optional feature: define MEMARB_RR_EN to alternate the winner on simultaneous
// I/D requests, using a last_grant flop. Without it the dcache always wins.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [DATA_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dwait,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic [1:0]        ramstate
);
  typedef enum logic [1:0] {ARB_IDLE, ARB_I, ARB_D} arb_state_t;
  localparam logic [1:0] RAM_ACCESS = 2'd2;
  arb_state_t state, next_state;
  logic d_req, access, pick_d;
  assign d_req  = dREN | dWEN;
  assign access = ramstate == RAM_ACCESS;
`ifdef MEMARB_RR_EN
  typedef enum logic {GRANT_I, GRANT_D} grant_t;
  grant_t last_grant;
  // On contention the requester that did not complete last wins.
  assign pick_d = d_req & (~iREN | (last_grant == GRANT_I));
  // Remember who completed the most recent transaction.
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) last_grant <= GRANT_I;
    else if (access && state == ARB_I) last_grant <= GRANT_I;
    else if (access && state == ARB_D) last_grant <= GRANT_D;
`else
  assign pick_d = d_req;
`endif
  // Grant register; reset aborts any transaction immediately.
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) state <= ARB_IDLE;
    else state <= next_state;
  // Next grant and RAM/requester signals decoded from the current grant.
  always_comb begin
    next_state = state;
    case (state)
      ARB_IDLE: next_state = pick_d ? ARB_D : iREN ? ARB_I : ARB_IDLE;
      ARB_I:    next_state = (!iREN || access) ? ARB_IDLE : ARB_I;
      ARB_D:    next_state = (!d_req || access) ? ARB_IDLE : ARB_D;
      default:  next_state = ARB_IDLE;
    endcase
    ramREN   = (state == ARB_I) ? iREN : (state == ARB_D) ? (dREN & ~dWEN) : 1'b0;
    ramWEN   = (state == ARB_D) & dWEN;
    ramaddr  = (state == ARB_I) ? iaddr : (state == ARB_D) ? daddr : '0;
    ramstore = (state == ARB_D) ? dstore : '0;
    iwait    = ~((state == ARB_I) & access);
    dwait    = ~((state == ARB_D) & access);
    iload    = ramload;
    dload    = ramload;
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter.
module tb_mem_arbiter;
  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;
  logic        CLK = 1'b0, nRST = 1'b0;
  logic        iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0;
  logic [31:0] iaddr = '0, daddr = '0, dstore = '0, ramload = '0;
  logic [1:0]  ramstate = FREE;
  logic        iwait, dwait, ramREN, ramWEN;
  logic [31:0] iload, dload, ramaddr, ramstore;
  int checks = 0, failures = 0;
  logic rr_i_first;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  always #5 CLK = ~CLK;

  task automatic cyc;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    iREN = 1'b1; dREN = 1'b1; daddr = 32'h10; iaddr = 32'h20; ramload = 32'hA5A5A5A5; ramstate = BUSY;
    @(negedge CLK);
    checks++; if (ramREN !== 1'b0) begin failures++; $display("FAIL reset_ramREN got=%0h exp=0", ramREN); end
    checks++; if (ramWEN !== 1'b0) begin failures++; $display("FAIL reset_ramWEN got=%0h exp=0", ramWEN); end
    checks++; if (iwait !== 1'b1 || dwait !== 1'b1) begin failures++; $display("FAIL reset_waits got=%0b%0b exp=11", iwait, dwait); end
    checks++; if (ramaddr !== 32'h0 || ramstore !== 32'h0) begin failures++; $display("FAIL reset_addr_store got=%h/%h exp=0/0", ramaddr, ramstore); end
    checks++; if (iload !== 32'hA5A5A5A5 || dload !== 32'hA5A5A5A5) begin failures++; $display("FAIL reset_loads got=%h/%h exp=a5a5a5a5", iload, dload); end
    @(negedge CLK);
    checks++; if (ramREN !== 1'b0) begin failures++; $display("FAIL reset_hold_ramREN got=%0h exp=0", ramREN); end
    cyc; nRST = 1'b1;
    @(negedge CLK);
    checks++; if (ramREN !== 1'b0) begin failures++; $display("FAIL reset_release_idle got=%0h exp=0", ramREN); end
    cyc;
    @(negedge CLK);
    checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h10) begin failures++; $display("FAIL reset_first_grant_d got=%0h/%h exp=1/00000010", ramREN, ramaddr); end
    checks++; if (iwait !== 1'b1 || dwait !== 1'b1) begin failures++; $display("FAIL reset_first_grant_waits got=%0b%0b exp=11", iwait, dwait); end
    cyc; iREN = 1'b0; dREN = 1'b0; ramstate = FREE;
    @(negedge CLK);
    checks++; if (ramREN !== 1'b0) begin failures++; $display("FAIL reset_drop got=%0h exp=0", ramREN); end
  endtask

  task automatic test_icache_read;
    cyc; iREN = 1'b1; iaddr = 32'h40; ramstate = ACCESS; ramload = 32'hDEADBEEF;
    @(negedge CLK);
    checks++; if (ramREN !== 1'b0 || iwait !== 1'b1) begin failures++; $display("FAIL iread_req_cycle got=%0h/%0h exp=0/1", ramREN, iwait); end
    cyc;
    @(negedge CLK);
    checks++; if (ramREN !== 1'b1 || ramWEN !== 1'b0 || ramaddr !== 32'h40) begin failures++; $display("FAIL iread_ram got=%0h/%0h/%h exp=1/0/00000040", ramREN, ramWEN, ramaddr); end
    checks++; if (iwait !== 1'b0 || iload !== 32'hDEADBEEF) begin failures++; $display("FAIL iread_data got=%0h/%h exp=0/deadbeef", iwait, iload); end
    checks++; if (dwait !== 1'b1) begin failures++; $display("FAIL iread_dwait got=%0h exp=1", dwait); end
    cyc;
    @(negedge CLK);
    checks++; if (ramREN !== 1'b0 || iwait !== 1'b1) begin failures++; $display("FAIL iread_idle_gap got=%0h/%0h exp=0/1", ramREN, iwait); end
    cyc;
    @(negedge CLK);
    checks++; if (iwait !== 1'b0 || ramREN !== 1'b1) begin failures++; $display("FAIL iread_back_to_back got=%0h/%0h exp=0/1", iwait, ramREN); end
    cyc; iREN = 1'b0;
    @(negedge CLK);
    checks++; if (iwait !== 1'b1 || ramREN !== 1'b0) begin failures++; $display("FAIL iread_end got=%0h/%0h exp=1/0", iwait, ramREN); end
  endtask

  task automatic test_dcache_write_busy;
    cyc; dWEN = 1'b1; dREN = 1'b1; daddr = 32'h100; dstore = 32'h12345678; ramstate = BUSY;
    @(negedge CLK);
    checks++; if (ramWEN !== 1'b0 || dwait !== 1'b1) begin failures++; $display("FAIL dwr_req_cycle got=%0h/%0h exp=0/1", ramWEN, dwait); end
    for (int k = 0; k < 3; k++) begin
      cyc;
      @(negedge CLK);
      checks++; if (ramWEN !== 1'b1 || ramREN !== 1'b0 || dwait !== 1'b1) begin failures++; $display("FAIL dwr_busy%0d got=%0h/%0h/%0h exp=1/0/1", k, ramWEN, ramREN, dwait); end
      checks++; if (ramaddr !== 32'h100 || ramstore !== 32'h12345678) begin failures++; $display("FAIL dwr_busy_bus%0d got=%h/%h exp=00000100/12345678", k, ramaddr, ramstore); end
    end
    cyc; ramstate = ACCESS;
    @(negedge CLK);
    checks++; if (dwait !== 1'b0 || ramWEN !== 1'b1) begin failures++; $display("FAIL dwr_access got=%0h/%0h exp=0/1", dwait, ramWEN); end
    cyc; ramstate = BUSY; dWEN = 1'b0; dREN = 1'b0;
    @(negedge CLK);
    checks++; if (dwait !== 1'b1 || ramWEN !== 1'b0 || ramstore !== 32'h0) begin failures++; $display("FAIL dwr_one_cycle got=%0h/%0h/%h exp=1/0/0", dwait, ramWEN, ramstore); end
  endtask

  task automatic test_contention;
    logic e_iw1, e_dw1, e_iw3, e_dw3;
    logic [31:0] e_a1, e_a3;
    e_iw1 = ~rr_i_first; e_dw1 = rr_i_first; e_iw3 = rr_i_first; e_dw3 = ~rr_i_first;
    e_a1 = rr_i_first ? 32'h44 : 32'h104;
    e_a3 = rr_i_first ? 32'h104 : 32'h44;
    cyc; iREN = 1'b1; dREN = 1'b1; iaddr = 32'h44; daddr = 32'h104; ramstate = ACCESS;
    @(negedge CLK);
    checks++; if (iwait !== 1'b1 || dwait !== 1'b1) begin failures++; $display("FAIL cont_c0 got=%0b%0b exp=11", iwait, dwait); end
    cyc;
    @(negedge CLK);
    checks++; if (iwait !== e_iw1 || dwait !== e_dw1 || ramaddr !== e_a1) begin failures++; $display("FAIL cont_c1 got=%0b%0b/%h exp=%0b%0b/%h", iwait, dwait, ramaddr, e_iw1, e_dw1, e_a1); end
    cyc; if (rr_i_first) iREN = 1'b0; else dREN = 1'b0;
    @(negedge CLK);
    checks++; if (iwait !== 1'b1 || dwait !== 1'b1 || ramREN !== 1'b0) begin failures++; $display("FAIL cont_c2 got=%0b%0b/%0b exp=11/0", iwait, dwait, ramREN); end
    cyc;
    @(negedge CLK);
    checks++; if (iwait !== e_iw3 || dwait !== e_dw3 || ramaddr !== e_a3) begin failures++; $display("FAIL cont_c3 got=%0b%0b/%h exp=%0b%0b/%h", iwait, dwait, ramaddr, e_iw3, e_dw3, e_a3); end
    cyc; iREN = 1'b0; dREN = 1'b0;
    @(negedge CLK);
    checks++; if (iwait !== 1'b1 || dwait !== 1'b1) begin failures++; $display("FAIL cont_c4 got=%0b%0b exp=11", iwait, dwait); end
  endtask

  task automatic test_withdraw;
    cyc; iREN = 1'b1; iaddr = 32'h80; ramstate = BUSY;
    @(negedge CLK);
    checks++; if (ramREN !== 1'b0) begin failures++; $display("FAIL wd_req got=%0h exp=0", ramREN); end
    cyc;
    @(negedge CLK);
    checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h80 || iwait !== 1'b1) begin failures++; $display("FAIL wd_granted got=%0h/%h/%0h exp=1/00000080/1", ramREN, ramaddr, iwait); end
    cyc; iREN = 1'b0; dREN = 1'b1; daddr = 32'h200;
    @(negedge CLK);
    checks++; if (ramREN !== 1'b0 || ramWEN !== 1'b0 || dwait !== 1'b1) begin failures++; $display("FAIL wd_drop got=%0h/%0h/%0h exp=0/0/1", ramREN, ramWEN, dwait); end
    cyc;
    @(negedge CLK);
    checks++; if (ramREN !== 1'b0 || ramaddr !== 32'h0) begin failures++; $display("FAIL wd_idle got=%0h/%h exp=0/0", ramREN, ramaddr); end
    cyc;
    @(negedge CLK);
    checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h200 || dwait !== 1'b1) begin failures++; $display("FAIL wd_d_grant got=%0h/%h/%0h exp=1/00000200/1", ramREN, ramaddr, dwait); end
    cyc; dREN = 1'b0;
    @(negedge CLK);
    checks++; if (ramREN !== 1'b0) begin failures++; $display("FAIL wd_end got=%0h exp=0", ramREN); end
  endtask

  task automatic test_error;
    cyc; dREN = 1'b1; daddr = 32'h300; ramstate = ERROR; ramload = 32'h0BADBAD0;
    @(negedge CLK);
    checks++; if (dwait !== 1'b1 || ramREN !== 1'b0) begin failures++; $display("FAIL err_req got=%0h/%0h exp=1/0", dwait, ramREN); end
    for (int k = 0; k < 2; k++) begin
      cyc;
      @(negedge CLK);
      checks++; if (dwait !== 1'b1 || ramREN !== 1'b1 || ramaddr !== 32'h300) begin failures++; $display("FAIL err_hold%0d got=%0h/%0h/%h exp=1/1/00000300", k, dwait, ramREN, ramaddr); end
    end
    cyc; ramstate = ACCESS; ramload = 32'hCAFEF00D;
    @(negedge CLK);
    checks++; if (dwait !== 1'b0 || dload !== 32'hCAFEF00D) begin failures++; $display("FAIL err_access got=%0h/%h exp=0/cafef00d", dwait, dload); end
    cyc; dREN = 1'b0; ramstate = BUSY;
    @(negedge CLK);
    checks++; if (dwait !== 1'b1 || ramREN !== 1'b0) begin failures++; $display("FAIL err_end got=%0h/%0h exp=1/0", dwait, ramREN); end
  endtask

  task automatic test_reset_mid;
    cyc; dREN = 1'b1; daddr = 32'h400; ramstate = BUSY;
    cyc;
    @(negedge CLK);
    checks++; if (ramREN !== 1'b1) begin failures++; $display("FAIL rmid_granted got=%0h exp=1", ramREN); end
    #2 nRST = 1'b0;
    #1;
    checks++; if (ramREN !== 1'b0 || ramaddr !== 32'h0 || dwait !== 1'b1) begin failures++; $display("FAIL rmid_abort got=%0h/%h/%0h exp=0/0/1", ramREN, ramaddr, dwait); end
    cyc; nRST = 1'b1; dREN = 1'b0;
    @(negedge CLK);
    checks++; if (ramREN !== 1'b0 || dwait !== 1'b1) begin failures++; $display("FAIL rmid_after got=%0h/%0h exp=0/1", ramREN, dwait); end
  endtask

  initial begin
`ifdef MEMARB_RR_EN
    rr_i_first = 1'b1;
`else
    rr_i_first = 1'b0;
`endif
    test_reset;
    test_icache_read;
    test_dcache_write_busy;
    test_contention;
    test_withdraw;
    test_error;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
